// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: opcodes, forward-select
// encoding, per-stage destination descriptor and the forwarding pick helper.
package hazard_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RS  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_PC4 = 2'b11
    } fwd_sel_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rs1_used;
        logic              rs2_used;
        logic              wr_en;
        logic              is_load;
        logic              is_jump;
    } stage_desc_t;

    typedef struct packed {
        fwd_sel_e sel;
        logic     pc4_wb;
    } fwd_t;

    localparam stage_desc_t DESC_BUBBLE = '0;

    // True when the reader descriptor sources the given writer's rd.
    function automatic logic reads_reg(input stage_desc_t rdr, input logic [REG_AW-1:0] rd);
        return (rdr.rs1_used && (rdr.rs1 == rd)) || (rdr.rs2_used && (rdr.rs2 == rd));
    endfunction

    // A writer hazards a reader only if it is live and actually writes a non-x0 rd.
    function automatic logic raw_hit(input stage_desc_t rdr, input stage_desc_t wr);
        return wr.valid && wr.wr_en && reads_reg(rdr, wr.rd);
    endfunction

    // Per-operand bypass source; MEM is younger so it wins over WB.
    function automatic fwd_t fwd_pick(input logic used, input logic [REG_AW-1:0] rs,
                                      input stage_desc_t mem, input stage_desc_t wb);
        fwd_t f;
        f.sel    = FWD_RS;
        f.pc4_wb = 1'b0;
        if (used && (rs != '0)) begin
            if (mem.valid && mem.wr_en && (mem.rd == rs)) begin
                f.sel = mem.is_jump ? FWD_PC4 : FWD_MEM;
            end else if (wb.valid && wb.wr_en && (wb.rd == rs)) begin
                f.sel    = wb.is_jump ? FWD_PC4 : FWD_WB;
                f.pc4_wb = wb.is_jump;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// ID-stage decoder: instruction word -> destination/source descriptor.
// Ports: instr_i (ID instruction), desc_o (combinational descriptor, valid=1).
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output stage_desc_t     desc_o
);

    logic [6:0] opcode;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign unused_instr = ^{instr_i[31:25], instr_i[14:12]};

    always_comb begin
        desc_o          = DESC_BUBBLE;
        desc_o.valid    = 1'b1;
        desc_o.rd       = instr_i[11:7];
        desc_o.rs1      = instr_i[19:15];
        desc_o.rs2      = instr_i[24:20];
        desc_o.rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        desc_o.rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        desc_o.is_load  = (opcode == OP_LOAD);
        desc_o.is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
        case (opcode)
            OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                desc_o.wr_en = (instr_i[11:7] != '0);
            default:
                desc_o.wr_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Tracks EX/MEM/WB destination descriptors and drives bypass selects,
// load-use / RAW stalls and branch flushes.
// Ports: i_clk, i_rst_n (async low), i_instr_ID, i_br_taken;
//        o_forward_a/b_sel, o_pc_plus_4_sela/b, o_stall_pc, o_stall_ifid,
//        o_flush_ifid, o_flush_idex.
// Build option: HAZARD_FWD_EN enables bypassing; without it every RAW on a
// live EX/MEM/WB writer stalls until the writer leaves WB.
module hazard_fwd_ctrl
    import hazard_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_instr_ID,
    input  logic            i_br_taken,
    output logic [1:0]      o_forward_a_sel,
    output logic [1:0]      o_forward_b_sel,
    output logic            o_pc_plus_4_sela,
    output logic            o_pc_plus_4_selb,
    output logic            o_stall_pc,
    output logic            o_stall_ifid,
    output logic            o_flush_ifid,
    output logic            o_flush_idex
);

    stage_desc_t id_desc;
    stage_desc_t ex_d, ex_q, mem_q, wb_q;
    logic        hazard;
    logic        br;
    logic        stall;
    logic        unused_desc;

    hazard_decode u_decode (
        .instr_i (i_instr_ID),
        .desc_o  (id_desc)
    );

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be bypassed in time.
    assign hazard = ex_q.is_load && raw_hit(id_desc, ex_q);
`else
    assign hazard = raw_hit(id_desc, ex_q) || raw_hit(id_desc, mem_q) || raw_hit(id_desc, wb_q);
`endif

    // Redirect wins: the stalled ID instruction is on the wrong path anyway.
    assign br    = i_br_taken && i_rst_n;
    assign stall = hazard && !br;

    assign o_stall_pc   = stall;
    assign o_stall_ifid = stall;
    assign o_flush_ifid = br;
    assign o_flush_idex = br || stall;

    assign ex_d = o_flush_idex ? DESC_BUBBLE : id_desc;

    // Descriptor pipeline EX -> MEM -> WB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q  <= DESC_BUBBLE;
            mem_q <= DESC_BUBBLE;
            wb_q  <= DESC_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

`ifdef HAZARD_FWD_EN
    fwd_t fwd_a, fwd_b;

    assign fwd_a = fwd_pick(ex_q.valid && ex_q.rs1_used, ex_q.rs1, mem_q, wb_q);
    assign fwd_b = fwd_pick(ex_q.valid && ex_q.rs2_used, ex_q.rs2, mem_q, wb_q);

    assign o_forward_a_sel  = fwd_a.sel;
    assign o_forward_b_sel  = fwd_b.sel;
    assign o_pc_plus_4_sela = fwd_a.pc4_wb;
    assign o_pc_plus_4_selb = fwd_b.pc4_wb;
`else
    assign o_forward_a_sel  = 2'b00;
    assign o_forward_b_sel  = 2'b00;
    assign o_pc_plus_4_sela = 1'b0;
    assign o_pc_plus_4_selb = 1'b0;
`endif

    assign unused_desc = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed self-checking bench for hazard_fwd_ctrl; expectations follow the
// build option HAZARD_FWD_EN.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        br_taken;
    logic [1:0]  fwd_a, fwd_b;
    logic        sela, selb, stall_pc, stall_ifid, flush_ifid, flush_idex;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    hazard_fwd_ctrl dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_instr_ID       (instr),
        .i_br_taken       (br_taken),
        .o_forward_a_sel  (fwd_a),
        .o_forward_b_sel  (fwd_b),
        .o_pc_plus_4_sela (sela),
        .o_pc_plus_4_selb (selb),
        .o_stall_pc       (stall_pc),
        .o_stall_ifid     (stall_ifid),
        .o_flush_ifid     (flush_ifid),
        .o_flush_idex     (flush_idex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, 3'd0, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'd8, rd, 7'b1101111};
    endfunction

    task automatic cmp(input string tag, input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s %s got %0b expected %0b", tag, name, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                       input logic esa, input logic esb, input logic est,
                       input logic efi, input logic efe);
        cmp(tag, "fwd_a", fwd_a, ea);
        cmp(tag, "fwd_b", fwd_b, eb);
        cmp(tag, "sela", {1'b0, sela}, {1'b0, esa});
        cmp(tag, "selb", {1'b0, selb}, {1'b0, esb});
        cmp(tag, "stall_pc", {1'b0, stall_pc}, {1'b0, est});
        cmp(tag, "stall_ifid", {1'b0, stall_ifid}, {1'b0, est});
        cmp(tag, "flush_ifid", {1'b0, flush_ifid}, {1'b0, efi});
        cmp(tag, "flush_idex", {1'b0, flush_idex}, {1'b0, efe});
    endtask

    task automatic step(input logic [31:0] ins, input logic br);
        @(negedge clk);
        instr    = ins;
        br_taken = br;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        instr    = r_add(5'd8, 5'd7, 5'd7);
        br_taken = 1'b1;
        #3;
        chk("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        instr    = NOP;
        br_taken = 1'b0;

`ifdef HAZARD_FWD_EN
        step(r_add(5'd5, 5'd1, 5'd2), 0); chk("first", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd6, 5'd5, 5'd1), 0); chk("alu_ex", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 0);                     chk("fwd_mem", 2'b10, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd5, 5'd1, 5'd2), 0); chk("idle1", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 0);                     chk("idle2", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd6, 5'd5, 5'd1), 0); chk("idle3", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 0);                     chk("fwd_wb", 2'b01, 2'b00, 0, 0, 0, 0, 0);
        step(lw(5'd7, 5'd1), 0);          chk("lw_id", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("lu_stall", 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("lu_bubble", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 0);                     chk("lu_fwd", 2'b01, 2'b01, 0, 0, 0, 0, 0);
        step(jal(5'd1), 0);               chk("jal_id", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd2, 5'd1, 5'd0), 0); chk("jal_ex", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 0);                     chk("pc4_mem", 2'b11, 2'b00, 0, 0, 0, 0, 0);
        step(jal(5'd1), 0);               chk("jal2_id", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 1);                     chk("jal_flush", 2'b00, 2'b00, 0, 0, 0, 1, 1);
        step(r_add(5'd2, 5'd1, 5'd0), 0); chk("jal_bub", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 0);                     chk("pc4_wb", 2'b11, 2'b00, 1, 0, 0, 0, 0);
        step(lw(5'd7, 5'd1), 0);          chk("br_lw", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd8, 5'd7, 5'd7), 1); chk("br_prio", 2'b00, 2'b00, 0, 0, 0, 1, 1);
        step(NOP, 0);                     chk("br_after", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(addi(5'd0, 5'd1), 0);        chk("x0_id", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd3, 5'd0, 5'd0), 0); chk("x0_ex", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(NOP, 0);                     chk("x0_mem", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(lw(5'd7, 5'd1), 0);          chk("rst_lw", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("rst_stall", 2'b00, 2'b00, 0, 0, 1, 0, 1);
`else
        step(r_add(5'd5, 5'd1, 5'd2), 0); chk("first", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd6, 5'd5, 5'd1), 0); chk("raw_ex", 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(r_add(5'd6, 5'd5, 5'd1), 0); chk("raw_mem", 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(r_add(5'd6, 5'd5, 5'd1), 0); chk("raw_wb", 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(r_add(5'd6, 5'd5, 5'd1), 0); chk("raw_done", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(lw(5'd7, 5'd1), 0);          chk("lw_id", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("lu_ex", 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("lu_mem", 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("lu_wb", 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("lu_done", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(lw(5'd7, 5'd1), 0);          chk("br_lw", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd8, 5'd7, 5'd7), 1); chk("br_prio", 2'b00, 2'b00, 0, 0, 0, 1, 1);
        step(NOP, 0);                     chk("br_after", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(addi(5'd0, 5'd1), 0);        chk("x0_id", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd3, 5'd0, 5'd0), 0); chk("x0_ex", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(lw(5'd7, 5'd1), 0);          chk("rst_lw", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(r_add(5'd8, 5'd7, 5'd7), 0); chk("rst_stall", 2'b00, 2'b00, 0, 0, 1, 0, 1);
`endif
        // Reset in the middle of a stall cycle: outputs drop at once.
        #1;
        rst_n    = 1'b0;
        br_taken = 1'b1;
        #1;
        chk("rst_mid", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        br_taken = 1'b0;
        instr    = r_add(5'd8, 5'd7, 5'd7);
        #1;
        chk("rst_clear", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
